countdown_sched: RTL and testbench

COUNTDOWN_SCHED -- requirements
Module: countdown_sched

---
 rtl/countdown_sched.sv | 127 ++++++++++++
 tb/tb_countdown_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_sched.sv
// countdown_sched: round-robin arbiter that lends one shared down-counter to NREQ requesters.
// The owner holds GNT from LOAD through FIN and gets a single DONE pulse when the count hits zero.
module countdown_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] load_val_i,
  input  logic              cancel_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic              busy_o,
  output logic [W-1:0]      cnt_o,
  output logic [NREQ-1:0]   done_o
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;

  logic [OW-1:0]   pickIdx;
  logic [OW-1:0]   candIdx;
  logic            pickFound;
  logic [W-1:0]    loadSlice;

  // owner_q doubles as last_owner: the search starts just past it and wraps around.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = owner_q;
    candIdx   = owner_q;
    for (int k = 1; k <= NREQ; k++) begin
      candIdx = OW'((int'(owner_q) + k) % NREQ);
      if (!pickFound && req_i[candIdx]) begin
        pickFound = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  always_comb begin
    loadSlice = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) begin
        loadSlice = load_val_i[i*W +: W];
      end
    end
  end

  // Every output is computed one cycle ahead so it can be driven straight from a flop.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          state_d        = LOAD;
          owner_d        = pickIdx;
          gnt_d          = '0;
          gnt_d[pickIdx] = 1'b1;
        end
      end
      LOAD: begin
        if (cancel_i) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else begin
          cnt_d   = loadSlice;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (cancel_i) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = FIN;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OW'(NREQ - 1);
      cnt_q   <= '1;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_countdown_sched.sv
// Scoreboard bench for countdown_sched: stimulus queues expected grants/completions from a
// transaction-level model, and a negedge monitor compares whatever the DUT presents.
module tb_countdown_sched;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int LW   = NREQ * W;

  typedef struct {
    int owner;
    int cycle;
  } event_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [LW-1:0]   loadVal;
  logic            cancel;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic [W-1:0]    cnt;
  logic [NREQ-1:0] done;

  event_t          grantQ[$];
  event_t          doneQ[$];
  event_t          monEv;
  logic [W-1:0]    expCnt[int];
  bit              expBusy[int];
  logic [NREQ-1:0] expGnt[int];

  int              cyc = 0;
  int              nCompared = 0;
  int              nMismatched = 0;
  bit              monOn = 1'b0;
  int              lastOwner;
  logic [W-1:0]    modelCnt;
  logic [NREQ-1:0] prevGnt = '0;

  countdown_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .load_val_i (loadVal),
    .cancel_i   (cancel),
    .gnt_o      (gnt),
    .busy_o     (busy),
    .cnt_o      (cnt),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Monitor: level checks against per-cycle expectations, event checks against the queues.
  always @(negedge clk) begin
    if (monOn) begin
      if (expCnt.exists(cyc)) begin
        checkOutput("cnt", 32'(cnt), 32'(expCnt[cyc]));
        expCnt.delete(cyc);
      end
      if (expBusy.exists(cyc)) begin
        checkOutput("busy", 32'(busy), 32'(expBusy[cyc]));
        expBusy.delete(cyc);
      end
      if (expGnt.exists(cyc)) begin
        checkOutput("gntLevel", 32'(gnt), 32'(expGnt[cyc]));
        expGnt.delete(cyc);
      end
      if (done !== '0) begin
        if (doneQ.size() == 0) begin
          checkOutput("doneUnexpected", 32'(done), 32'd0);
        end else begin
          monEv = doneQ.pop_front();
          checkOutput("doneOwner", 32'(done), 32'd1 << monEv.owner);
          checkOutput("doneCycle", 32'(cyc), 32'(monEv.cycle));
        end
        checkOutput("doneInGnt", 32'(done & ~gnt), 32'd0);
      end
      if (gnt !== '0 && prevGnt === '0) begin
        if (grantQ.size() == 0) begin
          checkOutput("grantUnexpected", 32'(gnt), 32'd0);
        end else begin
          monEv = grantQ.pop_front();
          checkOutput("grantOwner", 32'(gnt), 32'd1 << monEv.owner);
          checkOutput("grantCycle", 32'(cyc), 32'(monEv.cycle));
        end
      end
      prevGnt = gnt;
    end
  end

  function automatic int pickOwner(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(lastOwner + k) % NREQ]) return (lastOwner + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input bit withCancel);
    for (int i = 0; i < n; i++) begin
      expCnt[cyc]  = modelCnt;
      expBusy[cyc] = 1'b0;
      expGnt[cyc]  = '0;
      req    = '0;
      cancel = withCancel ? 1'($urandom_range(0, 1)) : 1'b0;
      stepCycle();
    end
    cancel = 1'b0;
  endtask

  // One grant from an IDLE cycle: offsets are relative to that IDLE cycle (offset 1 = LOAD).
  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [LW-1:0] lv,
                               input int cancelOff, input int rstOff, input bit strayCancel,
                               input logic [NREQ-1:0] laterReq, input logic [LW-1:0] laterLv);
    int t, owner, n, endOff;
    bit byCancel, byReset;
    logic [NREQ-1:0] oh;
    t     = cyc;
    owner = pickOwner(r);
    lastOwner = owner;
    n     = int'(lv[owner*W +: W]);
    oh    = '0;
    oh[owner] = 1'b1;
    byReset  = (rstOff >= 2 && rstOff <= n + 2);
    byCancel = !byReset && (cancelOff >= 1 && cancelOff <= n + 2);
    endOff   = byReset ? rstOff + 1 : (byCancel ? cancelOff + 1 : n + 4);
    grantQ.push_back('{owner, t + 1});
    if (!byReset && !byCancel) doneQ.push_back('{owner, t + n + 3});
    for (int off = 0; off < endOff; off++) begin
      int c;
      c = t + off;
      if (off <= 1)          expCnt[c] = modelCnt;
      else if (off <= n + 2) expCnt[c] = W'(n - (off - 2));
      else                   expCnt[c] = '0;
      expBusy[c] = (off != 0);
      expGnt[c]  = (off == 0) ? '0 : oh;
      req     = (off == 0) ? r : laterReq;
      loadVal = (off <= 1) ? lv : laterLv;
      cancel  = (off == cancelOff) || (strayCancel && (off == 0 || off == n + 3));
      rst     = byReset && (off == rstOff);
      stepCycle();
    end
    req = '0;
    cancel = 1'b0;
    rst = 1'b0;
    if (byReset) begin
      modelCnt  = '1;
      lastOwner = NREQ - 1;
    end else if (byCancel) begin
      if (cancelOff >= 2) modelCnt = W'(n - (cancelOff - 2));
    end else begin
      modelCnt = '0;
    end
  endtask

  initial begin
    logic [NREQ-1:0] r;
    logic [LW-1:0] lv;
    int mode, cOff, rOff;
    rst = 1'b1;
    req = '0;
    cancel = 1'b0;
    loadVal = '0;
    lastOwner = NREQ - 1;
    modelCnt = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    monOn = 1'b1;

    // Single owner, start value 3.
    applyStimulus(4'b0001, 16'h0003, -1, -1, 1'b0, 4'b0001, 16'h0003);
    // All requesting continuously: rotation.
    for (int i = 0; i < 5; i++)
      applyStimulus(4'b1111, 16'h2121, -1, -1, 1'b0, 4'b1111, 16'h2121);
    // Owner 2 cancelled when the count shows 2.
    applyStimulus(4'b0100, 16'h0500, 5, -1, 1'b0, 4'b0100, 16'h0500);
    // Zero start value, then zero start value cancelled on the zero-count cycle.
    applyStimulus(4'b0010, 16'h0000, -1, -1, 1'b0, 4'b0000, 16'h0000);
    applyStimulus(4'b1000, 16'h0000, 2, -1, 1'b0, 4'b0000, 16'h0000);
    // Reset mid-count at 4, then 1010 must go to requester 1.
    applyStimulus(4'b0001, 16'h0009, -1, 7, 1'b0, 4'b0001, 16'h0009);
    applyStimulus(4'b1010, 16'h0020, -1, -1, 1'b0, 4'b1010, 16'h0020);
    // Owner drops its request and LOAD_VAL changes mid-count; stray cancels in IDLE/FIN.
    applyStimulus(4'b0100, 16'h0600, -1, -1, 1'b1, 4'b0000, 16'hFFFF);
    idleCycles(3, 1'b1);

    for (int i = 0; i < 40; i++) begin
      r    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      lv   = LW'($urandom);
      mode = $urandom_range(0, 9);
      cOff = (mode < 3) ? $urandom_range(1, 18) : -1;
      rOff = (mode == 9) ? $urandom_range(2, 10) : -1;
      applyStimulus(r, lv, cOff, rOff, 1'($urandom_range(0, 1)), NREQ'($urandom), LW'($urandom));
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3), 1'b1);
    end

    idleCycles(2, 1'b0);
    checkOutput("grantQueueDrained", 32'(grantQ.size()), 32'd0);
    checkOutput("doneQueueDrained", 32'(doneQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
